// File: rtl/mips_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_instr_encoder                                                       |
// | Streams R/I/J instruction fields in, writes legal 32-bit MIPS words into |
// | instruction memory from BASE_ADDR. ENCODER_CHECKSUM_EN adds an XOR       |
// | checksum output over every word written in the session.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
`ifdef ENCODER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   c_depth    = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   c_depth_m1 = c_depth - 1'b1;
    localparam logic [ADDR_W-1:0] c_base     = BASE_ADDR[ADDR_W-1:0];

    localparam logic [1:0] c_fmt_r = 2'd0;
    localparam logic [1:0] c_fmt_i = 2'd1;
    localparam logic [1:0] c_fmt_j = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_xfer;
    logic              w_legal;
    logic              w_start_ok;
    logic [31:0]       w_word;

    function automatic logic f_i_opcode_legal(input logic [5:0] op);
        case (op)
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0F, 6'h23, 6'h28, 6'h29, 6'h2B: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic f_j_opcode_legal(input logic [5:0] op);
        return (op == 6'h02) || (op == 6'h03);
    endfunction

    assign in_ready   = (r_state == ST_LOAD) && (word_count < c_depth);
    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && (r_state != ST_LOAD);
    assign busy       = (r_state == ST_LOAD);
    assign done       = (r_state == ST_DONE) || (r_state == ST_FULL);

    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b0;
        case (in_fmt)
            c_fmt_r: begin
                w_word  = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
                w_legal = 1'b1;
            end
            c_fmt_i: begin
                w_word  = {in_opcode, in_rs, in_rt, in_imm};
                w_legal = f_i_opcode_legal(in_opcode);
            end
            c_fmt_j: begin
                w_word  = {in_opcode, in_target};
                w_legal = f_j_opcode_legal(in_opcode);
            end
            default: begin
                w_word  = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FULL: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_ptr      <= c_base;
                        word_count <= '0;
                        err        <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_ptr;
                            imem_wdata <= w_word;
                            r_ptr      <= r_ptr + 1'b1;
                            word_count <= word_count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        // in_last wins over running out of room on the same word
                        if (in_last) begin
                            r_state <= ST_DONE;
                        end else if (w_legal && (word_count == c_depth_m1)) begin
                            r_state <= ST_FULL;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ENCODER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= 32'h0000_0000;
        end else if (w_start_ok) begin
            checksum <= 32'h0000_0000;
        end else if (imem_we) begin
            checksum <= checksum ^ imem_wdata;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_instr_encoder                                                    |
// | Directed + random stimulus against a behavioural model of the encoder.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mips_instr_encoder;

    localparam int AW   = 3;
    localparam int DEP  = 4;
    localparam int BASE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, in_last, in_ready;
    logic [1:0]    in_fmt;
    logic [5:0]    in_opcode, in_funct;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          imem_we, err, busy, done;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
`ifdef ENCODER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    mips_instr_encoder #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .err(err),
`ifdef ENCODER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int legal_ops[15] = '{4, 5, 8, 9, 10, 11, 12, 13, 15, 35, 40, 41, 43, 2, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_legal(input int fmt, input int op);
        if (fmt == 0) return 1'b1;
        if (fmt == 2) return (op == 2) || (op == 3);
        if (fmt == 1)
            for (int k = 0; k < 13; k++) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input int fmt, input int op, input int rs,
            input int rt, input int rd, input int sh, input int fn, input int imm, input int tgt);
        if (fmt == 0) return 32'((rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn);
        if (fmt == 1) return 32'((op << 26) | (rs << 21) | (rt << 16) | imm);
        return 32'((op << 26) | tgt);
    endfunction

    bit            m_loading, m_finished, m_err, m_we;
    int            m_count;
    int            m_ptr;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata, m_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 0; m_finished = 0; m_err = 0; m_we = 0;
            m_count = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_sum = '0;
        end else begin
            bit take;
            take = in_valid && m_loading && (m_count < DEP);
            if (start && !m_loading) m_sum = '0;
            else if (m_we) m_sum = m_sum ^ m_wdata;
            m_we = 0;
            if (start && !m_loading) begin
                m_loading = 1; m_finished = 0; m_count = 0; m_err = 0; m_ptr = BASE;
            end else if (take) begin
                if (model_legal(int'(in_fmt), int'(in_opcode))) begin
                    m_we    = 1;
                    m_addr  = m_ptr[AW-1:0];
                    m_wdata = model_word(int'(in_fmt), int'(in_opcode), int'(in_rs), int'(in_rt),
                                         int'(in_rd), int'(in_shamt), int'(in_funct),
                                         int'(in_imm), int'(in_target));
                    m_ptr   = (m_ptr + 1) % (1 << AW);
                    m_count = m_count + 1;
                end else begin
                    m_err = 1;
                end
                if (in_last || m_count == DEP) begin
                    m_loading = 0; m_finished = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",   32'(in_ready),   32'(m_loading && (m_count < DEP)));
        chk("imem_we",    32'(imem_we),    32'(m_we));
        chk("imem_addr",  32'(imem_addr),  32'(m_addr));
        chk("imem_wdata", imem_wdata,      m_wdata);
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("err",        32'(err),        32'(m_err));
        chk("busy",       32'(busy),       32'(m_loading));
        chk("done",       32'(done),       32'(m_finished));
`ifdef ENCODER_CHECKSUM_EN
        chk("checksum",   checksum,        m_sum);
`endif
    end

    // ---------------- driver ----------------
    bit w_acc;

    task automatic step();
        @(negedge clk);
        w_acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic put(input int fmt, input int op, input int rs, input int rt, input int rd,
            input int sh, input int fn, input int imm, input int tgt,
            input bit last, input bit may_stall);
        in_fmt = fmt[1:0]; in_opcode = op[5:0]; in_rs = rs[4:0]; in_rt = rt[4:0];
        in_rd = rd[4:0]; in_shamt = sh[4:0]; in_funct = fn[5:0]; in_imm = imm[15:0];
        in_target = tgt[25:0]; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (w_acc) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!w_acc && !may_stall) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: in_ready never seen, expected a transfer");
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_fmt = '0;
        in_opcode = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0;
        #1 rst = 1'b1;
        step(); step();
        chk("pin_reset_we", 32'(imem_we), 32'd0);
        chk("pin_reset_ready", 32'(in_ready), 32'd0);
        chk("pin_reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        // add $3,$1,$2 as the only word
        pulse_start();
        put(0, 0, 1, 2, 3, 0, 32, 0, 0, 1, 0);
        chk("pin_add_we", 32'(imem_we), 32'd1);
        chk("pin_add_addr", 32'(imem_addr), 32'd6);
        chk("pin_add_word", imem_wdata, 32'h0022_1820);
        chk("pin_model_add", m_wdata, 32'h0022_1820);
        chk("pin_add_count", 32'(word_count), 32'd1);
        chk("pin_add_done", 32'(done), 32'd1);

        // add, lw, j back to back; third address wraps to 0
        pulse_start();
        chk("pin_start_count", 32'(word_count), 32'd0);
        put(0, 0, 1, 2, 3, 0, 32, 0, 0, 0, 0);
        put(1, 6'h23, 29, 8, 0, 0, 0, 16'h0004, 0, 0, 0);
        chk("pin_lw_word", imem_wdata, 32'h8FA8_0004);
        chk("pin_lw_addr", 32'(imem_addr), 32'd7);
        put(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h10, 1, 0);
        chk("pin_j_word", imem_wdata, 32'h0800_0010);
        chk("pin_j_addr_wrap", 32'(imem_addr), 32'd0);
        chk("pin_j_count", 32'(word_count), 32'd3);
`ifdef ENCODER_CHECKSUM_EN
        chk("pin_checksum", checksum, 32'h8F8A_1824);
`endif

        // illegal I opcode, reserved format, then beq
        pulse_start();
        put(1, 6'h3F, 1, 2, 0, 0, 0, 16'h1234, 0, 0, 0);
        chk("pin_illegal_we", 32'(imem_we), 32'd0);
        chk("pin_illegal_err", 32'(err), 32'd1);
        put(3, 6'h04, 1, 2, 0, 0, 0, 16'h1234, 0, 0, 0);
        chk("pin_fmt3_count", 32'(word_count), 32'd0);
        put(1, 6'h04, 1, 2, 0, 0, 0, 16'hFFFF, 0, 1, 0);
        chk("pin_beq_word", imem_wdata, 32'h1022_FFFF);
        chk("pin_beq_addr", 32'(imem_addr), 32'd6);
        chk("pin_beq_err_sticky", 32'(err), 32'd1);

        // fill to DEPTH without in_last
        pulse_start();
        for (int i = 0; i < 4; i++) put(0, 0, i, i + 1, i + 2, i, 6'h21, 0, 0, 0, 0);
        chk("pin_full_ready", 32'(in_ready), 32'd0);
        chk("pin_full_done", 32'(done), 32'd1);
        chk("pin_full_addr", 32'(imem_addr), 32'd1);
        chk("pin_full_count", 32'(word_count), 32'd4);
        put(0, 0, 5, 5, 5, 0, 6'h20, 0, 0, 0, 1);
        chk("pin_full_stall", 32'(w_acc), 32'd0);
        chk("pin_full_no_we", 32'(imem_we), 32'd0);

        // in_last on the DEPTH-th word
        pulse_start();
`ifdef ENCODER_CHECKSUM_EN
        chk("pin_checksum_clear", checksum, 32'd0);
`endif
        for (int i = 0; i < 4; i++) put(0, 0, i, 3, 7, 0, 6'h22, 0, 0, i == 3, 0);
        chk("pin_last_done", 32'(done), 32'd1);
        chk("pin_last_count", 32'(word_count), 32'd4);

        // reset while a transfer is being taken
        pulse_start();
        chk("pin_restart_busy", 32'(busy), 32'd1);
        in_fmt = 2'd0; in_rs = 5'd9; in_valid = 1'b1; in_last = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("pin_rst_we", 32'(imem_we), 32'd0);
        chk("pin_rst_busy", 32'(busy), 32'd0);
        chk("pin_rst_count", 32'(word_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("pin_after_rst_we", 32'(imem_we), 32'd0);
        pulse_start();
        put(0, 0, 4, 5, 6, 0, 6'h24, 0, 0, 1, 0);
        chk("pin_after_rst_addr", 32'(imem_addr), 32'd6);

        // random traffic, including start during LOAD and stray resets
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 5) == 0);
            in_fmt    = 2'($urandom_range(0, 3));
            in_opcode = ($urandom_range(0, 1) == 0) ? 6'(legal_ops[$urandom_range(0, 14)])
                                                   : 6'($urandom);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_funct = 6'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            step();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
